// File: rtl/counter_arb_pkg.sv
// rtl/counter_arb_pkg.sv - shared constants and state encoding for counter_arbiter
package counter_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 4;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    RUN  = STATE_RUN,
    DONE = STATE_DONE
  } state_t;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// rtl/counter_arbiter_rr_pick.sv - combinational round-robin selector
// Searches upward from ptr+1 with wrap; winner is one-hot, valid flags any request.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin owner of one shared interval counter
// Optional COUNTER_ARB_PAUSE_EN adds a pause input that freezes the count in RUN.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
`ifdef COUNTER_ARB_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      count
);

  localparam int PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] len_q;

  logic [NREQ-1:0] pick;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [CW-1:0]   pick_len;
  logic [NREQ-1:0] owner_bit;
  logic            hold;

`ifdef COUNTER_ARB_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        pick_len = len[i*CW +: CW];
      end
    end
  end

  assign owner_bit = NREQ'(1) << owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      ptr   <= PW'(NREQ - 1);
      owner <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= '0;
          count <= '0;
          if (pick_valid) begin
            owner <= pick_idx;
            ptr   <= pick_idx;
            len_q <= pick_len;
            gnt   <= pick;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        RUN: begin
          // Dropping the owner's request aborts silently; ptr already points at owner.
          if (!req[owner]) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            count <= '0;
          end else if (!hold) begin
            // len_q of 0 wraps to all-ones here, giving the full 2^CW interval.
            if (count == len_q - CW'(1)) begin
              state <= DONE;
              gnt   <= '0;
              done  <= owner_bit;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - randomized bench for counter_arbiter against an interval-level model
// Build with COUNTER_ARB_PAUSE_EN defined to also exercise pause.
module tb_counter_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int LMAX = 1 << CW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] len = '0;
`ifdef COUNTER_ARB_PAUSE_EN
  logic              pause = 1'b0;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;

  counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef COUNTER_ARB_PAUSE_EN
    .pause (pause),
`endif
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Interval-level model: who holds the counter, how long, how much has elapsed.
  int m_phase  = 0;   // 0 waiting, 1 counting, 2 completion pulse
  int m_owner  = 0;
  int m_len    = 1;
  int m_ticks  = 0;
  int m_last   = NREQ - 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int eff_len(input int i);
    int v;
    v = int'(len[i*CW +: CW]);
    return (v == 0) ? LMAX : v;
  endfunction

  task automatic model_step();
    bit paused;
    bit found;
    int idx;
    paused = 1'b0;
`ifdef COUNTER_ARB_PAUSE_EN
    paused = pause;
`endif
    if (rst) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_ticks = 0;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!found && req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      if (found) begin
        m_len   = eff_len(m_owner);
        m_last  = m_owner;
        m_ticks = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!req[m_owner]) m_phase = 0;
      else if (!paused) begin
        if (m_ticks + 1 == m_len) m_phase = 2;
        else m_ticks++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic tick();
    int e_count;
    @(posedge clk);
    #1;
    model_step();
    e_count = (m_phase == 0) ? 0 : (m_phase == 1) ? m_ticks : m_len - 1;
    check("gnt",   int'(gnt),   (m_phase == 1) ? (1 << m_owner) : 0);
    check("done",  int'(done),  (m_phase == 2) ? (1 << m_owner) : 0);
    check("busy",  int'(busy),  (m_phase != 0) ? 1 : 0);
    check("count", int'(count), e_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);

    // Single request, len=3
    req = 4'b0001; len = 16'h0003;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t <= 3) check("single_count", int'(count), t - 1);
      if (t <= 3) check("single_gnt", int'(gnt), 1);
      if (t == 4) begin
        check("single_done", int'(done), 1);
        check("single_busy4", int'(busy), 1);
        req = '0;
      end
      if (t == 5) check("single_idle_count", int'(count), 0);
    end

    // Zero length gives the full 2^CW interval
    req = 4'b0100; len = 16'h0000;
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 16) check("zero_count15", int'(count), 15);
      if (t == 17) begin
        check("zero_done", int'(done), 4'b0100);
        req = '0;
      end
    end
    tick();

    // Rotation with every requester holding len=1
    do_reset();
    req = 4'b1111; len = 16'h1111;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t % 3 == 1) check("rot_gnt", int'(gnt), 1 << (((t - 1) / 3) % NREQ));
    end
    req = '0;
    repeat (3) tick();

    // Abort: requester 1 drops at count 4, pending requester 2 wins next
    do_reset();
    req = 4'b0010; len = 16'h0080;
    tick();
    check("abort_gnt1", int'(gnt), 4'b0010);
    req = 4'b0111;
    repeat (4) tick();
    check("abort_count4", int'(count), 4);
    req = 4'b0101;
    tick();
    check("abort_no_done", int'(done), 0);
    check("abort_idle_gnt", int'(gnt), 0);
    check("abort_count0", int'(count), 0);
    tick();
    check("abort_next_gnt", int'(gnt), 4'b0100);
    req = '0;
    repeat (2) tick();

    // Reset mid-RUN
    do_reset();
    req = 4'b0010; len = 16'h8888;
    repeat (6) tick();
    check("midrst_count5", int'(count), 5);
    rst = 1'b1; req = 4'b0011;
    tick();
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    rst = 1'b0;
    tick();
    check("midrst_first", int'(gnt), 4'b0001);
    req = '0;
    repeat (2) tick();

`ifdef COUNTER_ARB_PAUSE_EN
    // Pause holds count for two RUN cycles
    do_reset();
    req = 4'b0001; len = 16'h0004;
    tick(); check("pause_c0", int'(count), 0);
    tick(); check("pause_c1", int'(count), 1);
    pause = 1'b1;
    tick(); check("pause_h1", int'(count), 1);
    tick(); check("pause_h2", int'(count), 1);
    pause = 1'b0;
    tick(); check("pause_c2", int'(count), 2);
    tick(); check("pause_c3", int'(count), 3);
    tick(); check("pause_done", int'(done), 1);
    req = '0;
    tick();
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (done[i] && $urandom_range(0, 1) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) len[i*CW +: CW] = CW'($urandom_range(0, LMAX - 1));
      end
      rst = ($urandom_range(0, 499) == 0);
`ifdef COUNTER_ARB_PAUSE_EN
      pause = ($urandom_range(0, 4) == 0);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
